// File: rtl/if_fetch_branch_ctrl.sv
// -----------------------------------------------------------------------------
// if_fetch_branch_ctrl
//
// IF-stage program counter plus the IF/ID pipeline register.
//
// A level "branch in ID" hold from the downstream hold logic becomes a single
// bubble, which lets the branch drain out of ID. Fetch then parks in BR_WAIT
// until EX resolves the branch:
//   - taken     : redirect the PC (target forced word-aligned) and insert a bubble
//   - not taken : resume sequential fetch at once
// If EX does not resolve within WAIT_MAX cycles, a sticky timeout flag is set
// and fetch resumes sequentially.
//
// A load-use stall freezes every register, including the FSM and the wait
// counter. EX is frozen too, so a resolution that arrives during the stall is
// applied on the first cycle after the stall releases.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous, active-high reset
//   PChold       in   branch in ID (from the branch hold logic)
//   IFIDhold     in   branch in ID (from the branch hold logic, OR'd with PChold)
//   lw_stall     in   load-use stall: freeze all state
//   br_valid_ex  in   EX resolves the outstanding branch this cycle
//   br_taken_ex  in   resolved outcome
//   br_target_ex in   taken target address
//   imem_rdata   in   instruction at imem_addr (combinational instruction memory)
//   imem_addr    out  current PC
//   ifid_instr   out  IF/ID instruction
//   ifid_pc4     out  IF/ID PC+4 of that instruction
//   ifid_valid   out  IF/ID holds a real instruction (0 = bubble)
//   br_timeout   out  sticky resolution-timeout flag, cleared only by rst
// -----------------------------------------------------------------------------
module if_fetch_branch_ctrl #(
    parameter int                   ADDR_W    = 32,
    parameter int                   INSTR_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = '0,
    parameter int                   WAIT_MAX  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 PChold,
    input  logic                 IFIDhold,
    input  logic                 lw_stall,
    input  logic                 br_valid_ex,
    input  logic                 br_taken_ex,
    input  logic [ADDR_W-1:0]    br_target_ex,
    input  logic [INSTR_W-1:0]   imem_rdata,
    output logic [ADDR_W-1:0]    imem_addr,
    output logic [INSTR_W-1:0]   ifid_instr,
    output logic [ADDR_W-1:0]    ifid_pc4,
    output logic                 ifid_valid,
    output logic                 br_timeout
);

    localparam int                CNT_W    = $clog2(WAIT_MAX) + 1;
    localparam logic [ADDR_W-1:0] PC_INC   = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ALIGN_MK = ~(ADDR_W'(3));
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WAIT_MAX - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        BR_WAIT = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0]   ifid_instr_q, ifid_instr_d;
    logic [ADDR_W-1:0]    ifid_pc4_q, ifid_pc4_d;
    logic                 ifid_valid_q, ifid_valid_d;
    logic                 br_timeout_q, br_timeout_d;

    logic                 hold_s;
    logic [ADDR_W-1:0]    pc_plus4_s;
    logic [ADDR_W-1:0]    tgt_aligned_s;

    assign hold_s        = PChold | IFIDhold;
    // Wraps naturally modulo 2^ADDR_W.
    assign pc_plus4_s    = pc_q + PC_INC;
    // Targets are forced onto a word boundary by clearing the low two bits.
    assign tgt_aligned_s = br_target_ex & ALIGN_MK;

    // Next-state, next-PC and IF/ID contents for one normal (non-stalled) edge.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        br_timeout_d = br_timeout_q;

        case (state_q)
            RUN: begin
                if (hold_s) begin
                    // One bubble lets the branch leave ID; the PC waits for EX.
                    ifid_instr_d = NOP_INSTR;
                    ifid_valid_d = 1'b0;
                    wait_cnt_d   = '0;
                    state_d      = BR_WAIT;
                end else begin
                    ifid_instr_d = imem_rdata;
                    ifid_pc4_d   = pc_plus4_s;
                    ifid_valid_d = 1'b1;
                    pc_d         = pc_plus4_s;
                end
            end
            BR_WAIT: begin
                // Hold is deliberately ignored here: only EX resolution or the
                // timeout leaves this state, so no second branch is accepted.
                if (br_valid_ex && br_taken_ex) begin
                    pc_d         = tgt_aligned_s;
                    ifid_instr_d = NOP_INSTR;
                    ifid_valid_d = 1'b0;
                    state_d      = RUN;
                end else if (br_valid_ex) begin
                    // Not taken: the instruction at pc is already the right one.
                    ifid_instr_d = imem_rdata;
                    ifid_pc4_d   = pc_plus4_s;
                    ifid_valid_d = 1'b1;
                    pc_d         = pc_plus4_s;
                    state_d      = RUN;
                end else if (wait_cnt_q < CNT_LAST) begin
                    wait_cnt_d   = wait_cnt_q + CNT_ONE;
                    ifid_instr_d = NOP_INSTR;
                    ifid_valid_d = 1'b0;
                end else begin
                    br_timeout_d = 1'b1;
                    ifid_instr_d = NOP_INSTR;
                    ifid_valid_d = 1'b0;
                    state_d      = RUN;
                end
            end
            default: begin
                // Unreachable encoding: recover to a clean RUN with a bubble.
                state_d      = RUN;
                wait_cnt_d   = '0;
                ifid_instr_d = NOP_INSTR;
                ifid_valid_d = 1'b0;
            end
        endcase
    end

    // State registers: reset first, then the load-use stall freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            wait_cnt_q   <= '0;
            pc_q         <= RESET_PC;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc4_q   <= '0;
            ifid_valid_q <= 1'b0;
            br_timeout_q <= 1'b0;
        end else if (lw_stall) begin
            state_q      <= state_q;
            wait_cnt_q   <= wait_cnt_q;
            pc_q         <= pc_q;
            ifid_instr_q <= ifid_instr_q;
            ifid_pc4_q   <= ifid_pc4_q;
            ifid_valid_q <= ifid_valid_q;
            br_timeout_q <= br_timeout_q;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
            br_timeout_q <= br_timeout_d;
        end
    end

    assign imem_addr  = pc_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_pc4   = ifid_pc4_q;
    assign ifid_valid = ifid_valid_q;
    assign br_timeout = br_timeout_q;

endmodule
